lcd_driver: RTL and testbench
=============================

// Module: lcd_driver
// PURPOSE
//  Downstream consumer of the LSU's io_lcd output register. Converts the memory-mapped LCD word written by software
//  into HD44780-compatible bus cycles (RS/data setup, EN pulse, hold, command execution wait) for the board's 16x2
//  character LCD. Software launches one bus write per flip of the toggle bit in the LCD word; this block owns all timing.
// PARAMETERS
//  T_SETUP_CYC    4       cycles RS/data stable with EN low before the EN pulse (min 1)
//  T_EN_CYC       24      cycles EN held high (min 1)
//  T_HOLD_CYC     4       cycles RS/data held with EN low after the pulse (min 1)
//  T_EXEC_CYC     2000    execution wait for normal commands and data (40 us @ 50 MHz)
//  T_CLEAR_CYC    82000   execution wait for clear (8'h01) and home (8'h02) commands (1.64 ms @ 50 MHz)
//  T_POWERUP_CYC  750000  power-up delay before the init sequence; used only with LCD_INIT_EN
// PORTS
//  clk_i       in   1   system clock
//  rst_ni      in   1   asynchronous active-low reset
//  lcd_reg_i   in   32  LSU io_lcd word: [31] ON, [10] TOGGLE, [9] RS, [8] RW (ignored), [7:0] DATA
//  lcd_on_o    out  1   LCD power/backlight enable
//  lcd_rs_o    out  1   register select to LCD (0 = command, 1 = data)
//  lcd_rw_o    out  1   read/write to LCD; always 0 (write-only driver)
//  lcd_en_o    out  1   LCD enable strobe
//  lcd_data_o  out  8   LCD data bus
//  lcd_busy_o  out  1   high while a transaction (or init) is in progress
// BEHAVIOUR
//  Reset
//  - All outputs 0. FSM in IDLE. last_toggle = 0. Counter = 0.
//  - Reset is asynchronous and may arrive in any state: lcd_en_o drops the same instant and the transaction is abandoned.
//  lcd_on_o
//  - Registered copy of lcd_reg_i[31] every cycle. 1-cycle latency. Independent of the FSM.
//  Launch
//  - Checked in IDLE only: if lcd_reg_i[10] != last_toggle, then at that edge:
//    - capture RS = [9] and DATA = [7:0] into output registers;
//    - last_toggle <= [10];
//    - go to SETUP; lcd_busy_o rises in the same cycle.
//  - rs/data stay constant until the next launch. They are not cleared in IDLE.
//  FSM: IDLE -> SETUP -> PULSE -> HOLD -> WAIT -> IDLE
//  - SETUP, PULSE and HOLD last exactly T_SETUP_CYC, T_EN_CYC and T_HOLD_CYC cycles respectively.
//  - lcd_en_o = 1 only in PULSE, and is registered (no glitches).
//  - WAIT lasts T_CLEAR_CYC if RS == 0 and DATA is 8'h01 or 8'h02; otherwise it lasts T_EXEC_CYC.
//  - lcd_busy_o = (state != IDLE). It falls in the cycle the FSM re-enters IDLE.
//  - A single down-counter is shared by all states. Width = $clog2(max(T_CLEAR_CYC, T_POWERUP_CYC) + 1).
//    It is reloaded on every state entry.
//  Boundary conditions
//  - Toggle flipped while busy: the request is held as pending (one-deep) and launches on the first IDLE cycle.
//    Total busy gap is 1 cycle.
//  - Even number of flips while busy: net no change, so nothing launches. Software must poll lcd_busy_o;
//    this is the documented limitation.
//  - lcd_reg_i changes to [9]/[7:0] during busy do not disturb the transaction in flight.
//  - lcd_reg_i[8] has no effect. lcd_rw_o is constant 0.
// CONFIGURATION
//  Macro: LCD_INIT_EN
//  - Defined: after reset the FSM enters PWRUP for T_POWERUP_CYC, then issues the commands 8'h38, 8'h0C, 8'h01, 8'h06
//    (RS = 0) through the normal SETUP..WAIT path. lcd_busy_o is held high throughout.
//    - User toggles during init are not lost: last_toggle compare starts in the first IDLE after init.
//  - Undefined: PWRUP and the init ROM are not compiled. The FSM is IDLE immediately after reset; software initialises the LCD.
// TESTING
//  (Bench parameters: T_SETUP_CYC=2, T_EN_CYC=3, T_HOLD_CYC=2, T_EXEC_CYC=10, T_CLEAR_CYC=40, T_POWERUP_CYC=20; macro off unless noted.)
//  1. Reset, lcd_reg_i = 0 for 10 cycles:
//     -> all outputs 0, busy 0, en never pulses.
//  2. lcd_reg_i = 32'h8000_0641:
//     -> next cycle busy = 1, rs = 1, data = 8'h41, on = 1;
//     -> en high for exactly 3 cycles, starting 2 cycles after busy rises;
//     -> busy high for 17 cycles total.
//  3. After test 2 idles, lcd_reg_i = 32'h8000_0001 (toggle back to 0, RS = 0, clear):
//     -> one en pulse; WAIT = 40 cycles; busy high for 47 cycles.
//  4. During busy from test 2, flip toggle once (data 8'h42):
//     -> second transaction with data 8'h42 starts 1 cycle after busy falls.
//     Repeat with two flips during busy:
//     -> no second transaction.
//  5. Assert rst_ni low while en = 1:
//     -> en, busy, rs, data go 0 immediately;
//     -> after release, IDLE with last_toggle = 0; lcd_reg_i[10] = 1 relaunches.
//  6. With LCD_INIT_EN defined, release reset:
//     -> busy = 1 through 20 PWRUP cycles, then four en pulses carrying 8'h38, 8'h0C, 8'h01, 8'h06 with rs = 0;
//     -> the 8'h01 pulse uses the 40-cycle wait;
//     -> busy falls afterward; a toggle flipped mid-init launches right after.

Source files
------------

// File: rtl/lcd_driver.sv
// HD44780-style bus sequencer driven by the LSU io_lcd word: one bus write per flip of the toggle bit.
// Optional power-up init sequence (0x38, 0x0C, 0x01, 0x06) is compiled in with `define LCD_INIT_EN.
module lcd_driver #(
  parameter int unsigned T_SETUP_CYC   = 4,
  parameter int unsigned T_EN_CYC      = 24,
  parameter int unsigned T_HOLD_CYC    = 4,
  parameter int unsigned T_EXEC_CYC    = 2000,
  parameter int unsigned T_CLEAR_CYC   = 82000,
  parameter int unsigned T_POWERUP_CYC = 750000
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [31:0] lcd_reg_i,
  output logic        lcd_on_o,
  output logic        lcd_rs_o,
  output logic        lcd_rw_o,
  output logic        lcd_en_o,
  output logic [7:0]  lcd_data_o,
  output logic        lcd_busy_o
);

  localparam int unsigned CNT_MAX = (T_CLEAR_CYC > T_POWERUP_CYC) ? T_CLEAR_CYC : T_POWERUP_CYC;
  localparam int unsigned CW      = $clog2(CNT_MAX + 1);

  // Each state lasts (load + 1) cycles, so every reload value is the duration minus one.
  localparam logic [CW-1:0] LD_SETUP   = CW'(T_SETUP_CYC - 1);
  localparam logic [CW-1:0] LD_EN      = CW'(T_EN_CYC - 1);
  localparam logic [CW-1:0] LD_HOLD    = CW'(T_HOLD_CYC - 1);
  localparam logic [CW-1:0] LD_EXEC    = CW'(T_EXEC_CYC - 1);
  localparam logic [CW-1:0] LD_CLEAR   = CW'(T_CLEAR_CYC - 1);
  localparam logic [CW-1:0] LD_POWERUP = CW'(T_POWERUP_CYC - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_SETUP, S_PULSE, S_HOLD, S_WAIT, S_BOOT, S_PWRUP
  } state_t;

  state_t        state_reg;
  logic [CW-1:0] cnt_reg;
  logic          last_toggle_reg;
  logic          rs_reg;
  logic [7:0]    data_reg;
  logic          en_reg;
  logic          busy_reg;
  logic          on_reg;
  logic          long_wait;

  // Clear and home need the long execution wait; everything else the short one.
  assign long_wait = ~rs_reg & ((data_reg == 8'h01) | (data_reg == 8'h02));

`ifdef LCD_INIT_EN
  localparam state_t RESET_STATE = S_BOOT;
  logic [2:0] init_idx_reg;
  logic [7:0] init_cmd;
  logic       init_more;

  always_comb begin
    case (init_idx_reg)
      3'd0:    init_cmd = 8'h38;
      3'd1:    init_cmd = 8'h0C;
      3'd2:    init_cmd = 8'h01;
      default: init_cmd = 8'h06;
    endcase
  end
  assign init_more = (init_idx_reg < 3'd4);
`else
  localparam state_t RESET_STATE = S_IDLE;
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_reg       <= RESET_STATE;
      cnt_reg         <= '0;
      last_toggle_reg <= 1'b0;
      rs_reg          <= 1'b0;
      data_reg        <= 8'h00;
      en_reg          <= 1'b0;
      busy_reg        <= 1'b0;
      on_reg          <= 1'b0;
`ifdef LCD_INIT_EN
      init_idx_reg    <= 3'd0;
`endif
    end else begin
      on_reg <= lcd_reg_i[31];
      case (state_reg)
        S_IDLE: begin
          if (lcd_reg_i[10] != last_toggle_reg) begin
            last_toggle_reg <= lcd_reg_i[10];
            rs_reg          <= lcd_reg_i[9];
            data_reg        <= lcd_reg_i[7:0];
            state_reg       <= S_SETUP;
            cnt_reg         <= LD_SETUP;
            busy_reg        <= 1'b1;
          end
        end
        S_SETUP: begin
          if (cnt_reg == '0) begin
            state_reg <= S_PULSE;
            cnt_reg   <= LD_EN;
            en_reg    <= 1'b1;
          end else begin
            cnt_reg <= cnt_reg - CW'(1);
          end
        end
        S_PULSE: begin
          if (cnt_reg == '0) begin
            state_reg <= S_HOLD;
            cnt_reg   <= LD_HOLD;
            en_reg    <= 1'b0;
          end else begin
            cnt_reg <= cnt_reg - CW'(1);
          end
        end
        S_HOLD: begin
          if (cnt_reg == '0) begin
            state_reg <= S_WAIT;
            cnt_reg   <= long_wait ? LD_CLEAR : LD_EXEC;
          end else begin
            cnt_reg <= cnt_reg - CW'(1);
          end
        end
        S_WAIT: begin
          if (cnt_reg == '0) begin
`ifdef LCD_INIT_EN
            // Init commands chain back-to-back so busy never drops mid-sequence.
            if (init_more) begin
              rs_reg       <= 1'b0;
              data_reg     <= init_cmd;
              init_idx_reg <= init_idx_reg + 3'd1;
              state_reg    <= S_SETUP;
              cnt_reg      <= LD_SETUP;
            end else begin
              state_reg <= S_IDLE;
              busy_reg  <= 1'b0;
            end
`else
            state_reg <= S_IDLE;
            busy_reg  <= 1'b0;
`endif
          end else begin
            cnt_reg <= cnt_reg - CW'(1);
          end
        end
`ifdef LCD_INIT_EN
        S_BOOT: begin
          state_reg <= S_PWRUP;
          cnt_reg   <= LD_POWERUP;
          busy_reg  <= 1'b1;
        end
        S_PWRUP: begin
          if (cnt_reg == '0) begin
            rs_reg       <= 1'b0;
            data_reg     <= init_cmd;
            init_idx_reg <= init_idx_reg + 3'd1;
            state_reg    <= S_SETUP;
            cnt_reg      <= LD_SETUP;
          end else begin
            cnt_reg <= cnt_reg - CW'(1);
          end
        end
`endif
        default: begin
          state_reg <= S_IDLE;
          en_reg    <= 1'b0;
          busy_reg  <= 1'b0;
        end
      endcase
    end
  end

  logic unused_bits;
  assign unused_bits = ^{lcd_reg_i[30:11], lcd_reg_i[8], LD_POWERUP};

  assign lcd_on_o   = on_reg;
  assign lcd_rs_o   = rs_reg;
  assign lcd_rw_o   = 1'b0;
  assign lcd_en_o   = en_reg;
  assign lcd_data_o = data_reg;
  assign lcd_busy_o = busy_reg;

endmodule

// File: tb/tb_lcd_driver.sv
// Self-checking bench for lcd_driver: vector table, hand-written corner sequences and a
// randomized run against a timeline model (busy/en derived from elapsed cycles per transaction).
module tb_lcd_driver;
  localparam int S  = 2;
  localparam int E  = 3;
  localparam int H  = 2;
  localparam int EX = 10;
  localparam int CL = 40;
  localparam int PU = 20;

  logic        clk = 1'b0;
  logic        rst_ni = 1'b0;
  logic [31:0] lcd_reg = 32'h0;
  logic        lcd_on, lcd_rs, lcd_rw, lcd_en, lcd_busy;
  logic [7:0]  lcd_data;

  lcd_driver #(
    .T_SETUP_CYC(S), .T_EN_CYC(E), .T_HOLD_CYC(H),
    .T_EXEC_CYC(EX), .T_CLEAR_CYC(CL), .T_POWERUP_CYC(PU)
  ) dut (
    .clk_i(clk), .rst_ni(rst_ni), .lcd_reg_i(lcd_reg),
    .lcd_on_o(lcd_on), .lcd_rs_o(lcd_rs), .lcd_rw_o(lcd_rw),
    .lcd_en_o(lcd_en), .lcd_data_o(lcd_data), .lcd_busy_o(lcd_busy)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  bit model_on = 1'b1;

  // Reference model: a transaction is a timeline of S setup, E enable, H hold and a wait cycles.
  bit       m_active, m_last, m_rs, m_on;
  logic [7:0] m_data;
  int       m_t, m_total;

  function automatic void model_reset();
    m_active = 0; m_last = 0; m_rs = 0; m_on = 0; m_data = 8'h00; m_t = 0; m_total = 0;
  endfunction

  function automatic void model_edge(logic [31:0] r);
    m_on = r[31];
    if (m_active) begin
      m_t++;
      if (m_t >= m_total) m_active = 0;
    end else if (r[10] != m_last) begin
      m_last   = r[10];
      m_rs     = r[9];
      m_data   = r[7:0];
      m_t      = 0;
      m_total  = S + E + H + ((!r[9] && (r[7:0] == 8'h01 || r[7:0] == 8'h02)) ? CL : EX);
      m_active = 1;
    end
  endfunction

  function automatic void chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  task automatic step();
    logic [12:0] act, exp;
    @(posedge clk);
    if (rst_ni) model_edge(lcd_reg);
    @(negedge clk);
    if (model_on) begin
      act = {lcd_on, lcd_rs, lcd_rw, lcd_en, lcd_data, lcd_busy};
      exp = {m_on, m_rs, 1'b0, (m_active && m_t >= S && m_t < S + E), m_data, m_active};
      chk("cycle", int'(act), int'(exp));
    end
  endtask

  typedef struct {
    logic [31:0] reg_val;
    int          busy_len;
    int          en_start;
    int          en_len;
    logic        rs;
    logic [7:0]  data;
  } vec_t;

  vec_t vecs[6];

  task automatic run_vec(input int idx, input vec_t v);
    bit seen = 0, done = 0;
    int busy_len = 0, en_start = -1, en_len = 0, lat = 0;
    logic rs_cap = 0;
    logic [7:0] data_cap = 8'h00;
    lcd_reg = v.reg_val;
    for (int c = 0; c < 200 && !done; c++) begin
      step();
      if (lcd_busy) begin
        if (!seen) begin seen = 1; rs_cap = lcd_rs; data_cap = lcd_data; lat = c + 1; end
        if (lcd_en) begin
          if (en_start < 0) en_start = busy_len;
          en_len++;
        end
        busy_len++;
      end else if (seen) done = 1;
    end
    chk("vec_done", int'(done), 1);
    chk("vec_latency", lat, 1);
    chk("vec_busy_len", busy_len, v.busy_len);
    chk("vec_en_start", en_start, v.en_start);
    chk("vec_en_len", en_len, v.en_len);
    chk("vec_rs", int'(rs_cap), int'(v.rs));
    chk("vec_data", int'(data_cap), int'(v.data));
    $display("vec %0d reg=%h busy=%0d en_start=%0d en_len=%0d rs=%0d data=%h",
             idx, v.reg_val, busy_len, en_start, en_len, rs_cap, data_cap);
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (lcd_busy && n < 200) begin step(); n++; end
    chk(name, int'(lcd_busy), 0);
  endtask

  initial begin
    model_reset();
`ifdef LCD_INIT_EN
    begin
      logic [7:0] pulses[$];
      logic [7:0] exp_p[5];
      bit prev_en = 0, fell = 0, rerise = 0;
      int first_len = 0, gap = 0;
      exp_p[0] = 8'h38; exp_p[1] = 8'h0C; exp_p[2] = 8'h01; exp_p[3] = 8'h06; exp_p[4] = 8'h77;
      model_on = 0;
      step();
      rst_ni = 1'b1;
      for (int c = 0; c < 400; c++) begin
        if (c == 60) lcd_reg = 32'h8000_0477;
        step();
        if (lcd_en && !prev_en) begin
          pulses.push_back(lcd_data);
          chk("init_rs", int'(lcd_rs), (pulses.size() == 5) ? 1 : 0);
        end
        prev_en = lcd_en;
        if (!fell) begin
          if (lcd_busy) first_len++; else if (first_len > 0) fell = 1;
        end
        if (fell && !rerise) begin
          if (lcd_busy) rerise = 1; else gap++;
        end
      end
      chk("init_busy_len", first_len, PU + 3 * (S + E + H + EX) + (S + E + H + CL));
      chk("init_gap", gap, 1);
      chk("init_pulses", pulses.size(), 5);
      for (int i = 0; i < 5; i++)
        chk("init_pulse_data", (i < pulses.size()) ? int'(pulses[i]) : -1, int'(exp_p[i]));
      $display("init sequence: %0d pulses, busy stretch %0d, gap %0d", pulses.size(), first_len, gap);
    end
`else
    // Reset held, then idle with zero input.
    step(); step();
    chk("reset_busy", int'(lcd_busy), 0);
    rst_ni = 1'b1;
    begin
      int en_cnt = 0;
      for (int c = 0; c < 10; c++) begin step(); en_cnt += int'(lcd_en); end
      chk("idle_en_pulses", en_cnt, 0);
    end

    vecs[0] = '{32'h8000_0641, 17, 2, 3, 1'b1, 8'h41};
    vecs[1] = '{32'h8000_0001, 47, 2, 3, 1'b0, 8'h01};
    vecs[2] = '{32'h0000_0402, 47, 2, 3, 1'b0, 8'h02};
    vecs[3] = '{32'h0000_0102, 47, 2, 3, 1'b0, 8'h02};
    vecs[4] = '{32'h8000_0601, 17, 2, 3, 1'b1, 8'h01};
    vecs[5] = '{32'h8000_0000, 17, 2, 3, 1'b0, 8'h00};
    for (int i = 0; i < 6; i++) run_vec(i, vecs[i]);

    // One flip while busy: second launch after a single idle cycle.
    begin
      int gap = 0, n = 0;
      lcd_reg = 32'h8000_0641;
      for (int c = 0; c < 5; c++) step();
      lcd_reg = 32'h8000_0042;
      wait_idle("pend_fall");
      while (!lcd_busy && n < 50) begin step(); gap++; n++; end
      chk("pend_gap", gap, 1);
      chk("pend_data", int'(lcd_data), 8'h42);
      $display("pending launch: gap=%0d data=%h", gap, lcd_data);
      wait_idle("pend_done");
    end

    // Two flips while busy: nothing further launches.
    begin
      int busy_cnt = 0;
      lcd_reg = 32'h8000_0641;
      for (int c = 0; c < 3; c++) step();
      lcd_reg = 32'h8000_0042;
      step(); step();
      lcd_reg = 32'h8000_0643;
      wait_idle("dbl_fall");
      for (int c = 0; c < 20; c++) begin step(); busy_cnt += int'(lcd_busy); end
      chk("dbl_no_launch", busy_cnt, 0);
      chk("dbl_data", int'(lcd_data), 8'h41);
      $display("double flip: busy cycles after idle=%0d", busy_cnt);
    end

    // Asynchronous reset during the enable pulse.
    begin
      int n = 0;
      lcd_reg = 32'h8000_0055;
      step();
      while (!lcd_en && n < 20) begin step(); n++; end
      chk("rst_saw_en", int'(lcd_en), 1);
      rst_ni = 1'b0;
      #1;
      chk("rst_async_outputs", int'({lcd_on, lcd_rs, lcd_rw, lcd_en, lcd_data, lcd_busy}), 0);
      model_reset();
      lcd_reg = 32'h0000_0466;
      step();
      rst_ni = 1'b1;
      step();
      chk("rst_relaunch_busy", int'(lcd_busy), 1);
      chk("rst_relaunch_data", int'(lcd_data), 8'h66);
      $display("reset during pulse: relaunch busy=%0d data=%h", lcd_busy, lcd_data);
      wait_idle("rst_done");
    end

    // Randomized traffic: occasional toggle flips, all other bits random every cycle.
    begin
      logic tog;
      logic [31:0] r;
      tog = lcd_reg[10];
      for (int c = 0; c < 1500; c++) begin
        if ($urandom_range(0, 11) == 0) tog = ~tog;
        r = $urandom;
        r[10] = tog;
        if ($urandom_range(0, 3) == 0) r[7:0] = 8'($urandom_range(1, 2));
        lcd_reg = r;
        step();
      end
      $display("random run complete");
    end
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
